tx_bank_sched: RTL and testbench
================================

Name: tx_bank_sched

Overview:
- Schedules the banked TX buffer between the command decoder (bank writer) and the USB slave-FIFO reader.
- Bank 0 is reserved for handshake replies. Banks 1..2^BADDR_NBIT-1 form a data ring.
- Tracks filled and free banks, gives handshake replies strict priority, issues one start-of-packet per bank, and waits for completion before issuing the next.
- Runs entirely in the mclk domain. Crossings to usb_clk are done by synchronizers outside this block.

Parameters:
- BADDR_NBIT, 3: bank address width. NB = 2^BADDR_NBIT banks; NB-1 data banks.
- TMO_NBIT, 16: width of the completion-watchdog counter. Timeout is 2^TMO_NBIT-1 mclk cycles.

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all pending banks and aborts any transfer
- wr_done  in  1  one-cycle pulse; writer has finished filling a bank
- wr_hs  in  1  qualifies wr_done: 1 = handshake bank 0 filled, 0 = data bank wr_baddr filled
- wr_baddr  out  BADDR_NBIT  data bank the writer must fill next
- wr_ready  out  1  a free data bank exists
- usb_full  in  1  level; EP6 full
- tx_sop  out  1  one-cycle start-of-packet pulse to the USB reader
- tx_baddr  out  BADDR_NBIT  bank to transmit; valid from the tx_sop cycle until tx_done
- tx_done  in  1  one-cycle pulse; packet fully handed to the USB PHY
- busy  out  1  state != IDLE
- pending  out  BADDR_NBIT  number of filled, unsent data banks
- overflow  out  1  sticky; a write arrived with no free target
- timeout  out  1  sticky; watchdog expired

Behaviour:
- Reset values:
  - wptr = rptr = 1, count = 0, hs_pend = 0, state = IDLE.
  - tx_sop = 0, tx_baddr = 0, wr_baddr = 1, wr_ready = 1, busy = 0, pending = 0, overflow = 0, timeout = 0.
  - Asserting reset mid-transfer abandons the transfer; no tx_sop follows.
- Pointer wrap: wptr and rptr advance as 1, 2, …, NB-1, 1. Value 0 is never a data pointer.
- wr_baddr = wptr. wr_ready = (count < NB-1). pending = count.
- Write side, on wr_done:
  - wr_hs = 1: set hs_pend. If hs_pend is already set, also set overflow; the second reply overwrites the first.
  - wr_hs = 0 and count < NB-1: advance wptr, count += 1.
  - wr_hs = 0 and count = NB-1: set overflow; pointers and count are unchanged (write dropped).
- State machine: IDLE → ISSUE → WAIT → IDLE.
  - IDLE, priority 1: if hs_pend, set tx_baddr = 0 and go to ISSUE. usb_full is ignored for handshakes.
  - IDLE, priority 2: else if count > 0 and !usb_full, set tx_baddr = rptr and go to ISSUE.
  - ISSUE: tx_sop = 1 for exactly this cycle; clear the watchdog; go to WAIT.
  - The condition is sampled at edge k; tx_sop is high in cycle k+1.
- WAIT, on tx_done:
  - If tx_baddr = 0: clear hs_pend.
  - Else: advance rptr, count -= 1.
  - Go to IDLE. The next tx_sop can come no earlier than 2 cycles after tx_done.
- WAIT, without tx_done: the watchdog increments each cycle.
  - On reaching 2^TMO_NBIT-1: set timeout and return to IDLE without freeing the bank. The same bank is reissued (retry).
- tx_done in IDLE or ISSUE is ignored.
- Simultaneous data wr_done and a data tx_done in the same cycle:
  - count is unchanged; both pointers advance.
  - This write is accepted even when count = NB-1, because a slot frees in the same cycle.
- A handshake wr_done while a handshake is in WAIT:
  - Sets overflow.
  - hs_pend stays set for the new reply: tx_done clears hs_pend only if no new handshake wr_done arrived in the same cycle.
- flush has priority over every other input except reset.
  - Clears wptr and rptr to 1, count to 0, hs_pend to 0; state goes to IDLE; tx_sop goes to 0.
  - overflow and timeout are cleared only by flush or reset.

Test Plan:
- Three data wr_done pulses with usb_full = 0 → tx_sop sequence with tx_baddr = 1, 2, 3. Each tx_sop follows the prior tx_done by 2 cycles. pending goes 3 → 0.
- Data banks 1 and 2 pending; handshake wr_done arrives while bank 1 is in WAIT → next tx_sop has tx_baddr = 0, then tx_baddr = 2.
- usb_full = 1 with count = 2 → no tx_sop. A handshake still issues with tx_baddr = 0. After usb_full drops, tx_baddr = 1 issues.
- Eight data wr_done pulses with BADDR_NBIT = 3 and no tx_done → wr_ready = 0 after the 7th, overflow = 1 after the 8th, pending = 7. wptr wraps 7 → 1.
- Withhold tx_done for 2^TMO_NBIT-1 cycles (TMO_NBIT = 4 in the bench) → timeout = 1, and the same tx_baddr is reissued.
- flush asserted in WAIT with pending = 4 → next cycle: busy = 0, pending = 0, wr_baddr = 1, no further tx_sop.

Source files
------------

// File: rtl/tx_bank_sched_if.sv
// Writer, USB-reader and status signals of the banked TX buffer scheduler.
// The master side (writer/reader/control) drives inputs; the scheduler is the slave.
interface tx_bank_sched_if #(
    parameter int BADDR_NBIT = 3
);
    logic                  flush;
    logic                  wr_done;
    logic                  wr_hs;
    logic [BADDR_NBIT-1:0] wr_baddr;
    logic                  wr_ready;
    logic                  usb_full;
    logic                  tx_sop;
    logic [BADDR_NBIT-1:0] tx_baddr;
    logic                  tx_done;
    logic                  busy;
    logic [BADDR_NBIT-1:0] pending;
    logic                  overflow;
    logic                  timeout;

    modport master (
        output flush, wr_done, wr_hs, usb_full, tx_done,
        input  wr_baddr, wr_ready, tx_sop, tx_baddr, busy, pending, overflow, timeout
    );

    modport slave (
        input  flush, wr_done, wr_hs, usb_full, tx_done,
        output wr_baddr, wr_ready, tx_sop, tx_baddr, busy, pending, overflow, timeout
    );
endinterface

// File: rtl/tx_bank_sched.sv
// Banked TX buffer scheduler: bank 0 carries handshake replies with strict priority,
// banks 1..NB-1 form a data ring; one start-of-packet per bank, completion-watchdog retry.
module tx_bank_sched #(
    parameter int BADDR_NBIT = 3,
    parameter int TMO_NBIT   = 16
) (
    input  logic             mclk,
    input  logic             reset,
    tx_bank_sched_if.slave   bus
);
    localparam int NB = 1 << BADDR_NBIT;
    localparam logic [BADDR_NBIT-1:0] LAST_BANK = BADDR_NBIT'(NB - 1);
    localparam logic [BADDR_NBIT-1:0] FIRST_BANK = BADDR_NBIT'(1);
    // Watchdog value in the last WAIT cycle before it reaches 2^TMO_NBIT-1.
    localparam logic [TMO_NBIT-1:0] TMO_LAST = {{(TMO_NBIT-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BADDR_NBIT-1:0] r_wptr;
    logic [BADDR_NBIT-1:0] r_rptr;
    logic [BADDR_NBIT-1:0] r_count;
    logic [BADDR_NBIT-1:0] r_tx_baddr;
    logic [TMO_NBIT-1:0]   r_wdog;
    logic                  r_hs_pend;
    logic                  r_overflow;
    logic                  r_timeout;

    logic w_done_acc;
    logic w_tmo_hit;
    logic w_data_free;
    logic w_hs_wr;
    logic w_data_wr;
    logic w_full;
    logic w_data_acc;
    logic w_issue_hs;
    logic w_issue_data;

    function automatic logic [BADDR_NBIT-1:0] ptr_inc(input logic [BADDR_NBIT-1:0] p);
        return (p == LAST_BANK) ? FIRST_BANK : p + FIRST_BANK;
    endfunction

    assign w_done_acc  = (r_state == S_WAIT) && bus.tx_done;
    assign w_tmo_hit   = (r_state == S_WAIT) && !bus.tx_done && (r_wdog == TMO_LAST);
    assign w_data_free = w_done_acc && (r_tx_baddr != '0);
    assign w_hs_wr     = bus.wr_done && bus.wr_hs;
    assign w_data_wr   = bus.wr_done && !bus.wr_hs;
    assign w_full      = (r_count == LAST_BANK);
    // A full ring still accepts a write when the bank in flight frees this same cycle.
    assign w_data_acc  = w_data_wr && (!w_full || w_data_free);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_hs   = 1'b0;
        w_issue_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hs_pend) begin
                    w_issue_hs  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if ((r_count != '0) && !bus.usb_full) begin
                    w_issue_data = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done_acc || w_tmo_hit) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wptr     <= FIRST_BANK;
            r_rptr     <= FIRST_BANK;
            r_count    <= '0;
            r_tx_baddr <= '0;
            r_wdog     <= '0;
            r_hs_pend  <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (bus.flush) begin
            r_state    <= S_IDLE;
            r_wptr     <= FIRST_BANK;
            r_rptr     <= FIRST_BANK;
            r_count    <= '0;
            r_wdog     <= '0;
            r_hs_pend  <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_issue_hs)        r_tx_baddr <= '0;
            else if (w_issue_data) r_tx_baddr <= r_rptr;

            if (r_state == S_ISSUE)                     r_wdog <= '0;
            else if ((r_state == S_WAIT) && !bus.tx_done) r_wdog <= r_wdog + TMO_NBIT'(1);

            if (w_tmo_hit) r_timeout <= 1'b1;

            // A new reply landing with the old one's tx_done keeps hs_pend set.
            if (w_hs_wr)                                 r_hs_pend <= 1'b1;
            else if (w_done_acc && (r_tx_baddr == '0))   r_hs_pend <= 1'b0;

            if ((w_hs_wr && r_hs_pend) || (w_data_wr && !w_data_acc)) r_overflow <= 1'b1;

            if (w_data_acc)  r_wptr <= ptr_inc(r_wptr);
            if (w_data_free) r_rptr <= ptr_inc(r_rptr);

            if (w_data_acc && !w_data_free)      r_count <= r_count + FIRST_BANK;
            else if (!w_data_acc && w_data_free) r_count <= r_count - FIRST_BANK;
        end
    end

    assign bus.wr_baddr = r_wptr;
    assign bus.wr_ready = !w_full;
    assign bus.pending  = r_count;
    assign bus.tx_sop   = (r_state == S_ISSUE);
    assign bus.tx_baddr = r_tx_baddr;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.overflow = r_overflow;
    assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_tx_bank_sched.sv
// Directed bench for tx_bank_sched: a queue-based model of the bank ring is compared
// against the DUT every cycle, plus hand-computed literal checks at key points.
module tb_tx_bank_sched;
    localparam int BN      = 3;
    localparam int TN      = 4;
    localparam int NB      = 1 << BN;
    localparam int TMO_CYC = (1 << TN) - 1;

    logic mclk  = 1'b0;
    logic reset = 1'b1;

    tx_bank_sched_if #(.BADDR_NBIT(BN)) bus ();

    tx_bank_sched #(.BADDR_NBIT(BN), .TMO_NBIT(TN)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of filled data banks (front = oldest, still held while in flight).
    int m_q[$];
    int m_next_w;
    int m_phase;  // 0 idle, 1 start-of-packet cycle, 2 awaiting completion
    int m_cur;
    int m_age;
    int m_txb;
    bit m_hs;
    bit m_ovf;
    bit m_tmo;

    task automatic model_reset();
        m_q.delete();
        m_next_w = 1;
        m_phase  = 0;
        m_cur    = 0;
        m_age    = 0;
        m_txb    = 0;
        m_hs     = 1'b0;
        m_ovf    = 1'b0;
        m_tmo    = 1'b0;
    endtask

    task automatic model_step();
        int  ph;
        int  qn;
        bit  hs0;
        bit  done_acc;
        bit  freed;
        ph  = m_phase;
        qn  = m_q.size();
        hs0 = m_hs;
        if (bus.flush) begin
            m_q.delete();
            m_next_w = 1;
            m_phase  = 0;
            m_age    = 0;
            m_hs     = 1'b0;
            m_ovf    = 1'b0;
            m_tmo    = 1'b0;
            return;
        end
        done_acc = (ph == 2) && bus.tx_done;
        freed    = done_acc && (m_cur != 0);
        case (ph)
            0: begin
                if (hs0) begin
                    m_cur = 0; m_txb = 0; m_phase = 1;
                end else if (qn > 0 && !bus.usb_full) begin
                    m_cur = m_q[0]; m_txb = m_cur; m_phase = 1;
                end
            end
            1: begin
                m_phase = 2; m_age = 0;
            end
            default: begin
                if (done_acc) m_phase = 0;
                else begin
                    m_age++;
                    if (m_age == TMO_CYC) begin
                        m_tmo = 1'b1; m_phase = 0;
                    end
                end
            end
        endcase
        if (done_acc) begin
            if (m_cur == 0) begin
                if (!(bus.wr_done && bus.wr_hs)) m_hs = 1'b0;
            end else begin
                void'(m_q.pop_front());
            end
        end
        if (bus.wr_done && bus.wr_hs) begin
            if (hs0) m_ovf = 1'b1;
            m_hs = 1'b1;
        end
        if (bus.wr_done && !bus.wr_hs) begin
            if (qn < NB - 1 || freed) begin
                m_q.push_back(m_next_w);
                m_next_w = (m_next_w == NB - 1) ? 1 : m_next_w + 1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    always @(posedge mclk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge mclk) begin
        if (cmp_en) begin
            check("cmp_tx_sop",   32'(bus.tx_sop),   32'(m_phase == 1));
            check("cmp_tx_baddr", 32'(bus.tx_baddr), 32'(m_txb));
            check("cmp_wr_baddr", 32'(bus.wr_baddr), 32'(m_next_w));
            check("cmp_wr_ready", 32'(bus.wr_ready), 32'(m_q.size() < NB - 1));
            check("cmp_busy",     32'(bus.busy),     32'(m_phase != 0));
            check("cmp_pending",  32'(bus.pending),  32'(m_q.size()));
            check("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
            check("cmp_timeout",  32'(bus.timeout),  32'(m_tmo));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wr_data();
        bus.wr_done = 1'b1; bus.wr_hs = 1'b0;
        tick();
        bus.wr_done = 1'b0;
    endtask

    task automatic wr_hs();
        bus.wr_done = 1'b1; bus.wr_hs = 1'b1;
        tick();
        bus.wr_done = 1'b0; bus.wr_hs = 1'b0;
    endtask

    task automatic done_pulse();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    // Waits at most `budget` cycles for tx_sop; an expired bound is a failed check.
    task automatic wait_sop(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.tx_sop === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic count_sops(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.tx_sop === 1'b1) c++;
        end
    endtask

    int c;
    int gap;

    initial begin
        bus.flush = 1'b0; bus.wr_done = 1'b0; bus.wr_hs = 1'b0;
        bus.usb_full = 1'b0; bus.tx_done = 1'b0;
        tick(2);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_wr_baddr", 32'(bus.wr_baddr), 1);
        check("rst_wr_ready", 32'(bus.wr_ready), 1);
        check("rst_tx_baddr", 32'(bus.tx_baddr), 0);
        check("rst_flags", 32'({bus.overflow, bus.timeout, bus.tx_sop}), 0);

        // Stray tx_done in IDLE is ignored
        done_pulse();
        check("idle_done_pending", 32'(bus.pending), 0);

        // Three data banks issued in order, 2 cycles after each tx_done
        bus.usb_full = 1'b1;
        repeat (3) wr_data();
        check("t1_pending3", 32'(bus.pending), 3);
        bus.usb_full = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_sop("t1_sop", 10);
            check("t1_tx_baddr", 32'(bus.tx_baddr), 32'(k));
            tick(3);
            done_pulse();
            check("t1_pending", 32'(bus.pending), 32'(3 - k));
            check("t1_gap1", 32'(bus.tx_sop), 0);
            tick();
            check("t1_gap2", 32'(bus.tx_sop), 32'(k < 3));
        end

        // Handshake pre-empts the remaining data bank
        flush_pulse();
        bus.usb_full = 1'b1;
        repeat (2) wr_data();
        bus.usb_full = 1'b0;
        wait_sop("t2_sop1", 10);
        check("t2_baddr1", 32'(bus.tx_baddr), 1);
        tick();
        wr_hs();
        tick();
        done_pulse();
        wait_sop("t2_sop_hs", 10);
        check("t2_baddr_hs", 32'(bus.tx_baddr), 0);
        tick();
        done_pulse();
        wait_sop("t2_sop2", 10);
        check("t2_baddr2", 32'(bus.tx_baddr), 2);
        tick();
        done_pulse();
        check("t2_pending", 32'(bus.pending), 0);

        // usb_full blocks data but not handshakes
        flush_pulse();
        bus.usb_full = 1'b1;
        repeat (2) wr_data();
        count_sops(8, c);
        check("t3_blocked", 32'(c), 0);
        check("t3_busy", 32'(bus.busy), 0);
        wr_hs();
        wait_sop("t3_sop_hs", 10);
        check("t3_baddr_hs", 32'(bus.tx_baddr), 0);
        tick();
        done_pulse();
        count_sops(6, c);
        check("t3_still_blocked", 32'(c), 0);
        bus.usb_full = 1'b0;
        wait_sop("t3_sop1", 10);
        check("t3_baddr1", 32'(bus.tx_baddr), 1);
        tick();
        done_pulse();
        wait_sop("t3_sop2", 10);
        check("t3_baddr2", 32'(bus.tx_baddr), 2);
        tick();
        done_pulse();

        // Fill the ring, overflow on the eighth write, pointer wrap
        flush_pulse();
        bus.usb_full = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data();
            if (i == 6) check("t4_wr_baddr6", 32'(bus.wr_baddr), 7);
            if (i == 7) begin
                check("t4_wr_ready7", 32'(bus.wr_ready), 0);
                check("t4_wrap", 32'(bus.wr_baddr), 1);
                check("t4_ovf7", 32'(bus.overflow), 0);
            end
        end
        check("t4_ovf8", 32'(bus.overflow), 1);
        check("t4_pending8", 32'(bus.pending), 7);
        check("t4_wr_baddr8", 32'(bus.wr_baddr), 1);

        // Write and completion in the same cycle on a full ring
        bus.usb_full = 1'b0;
        wait_sop("t4_sop", 10);
        tick();
        bus.wr_done = 1'b1; bus.wr_hs = 1'b0; bus.tx_done = 1'b1;
        tick();
        bus.wr_done = 1'b0; bus.tx_done = 1'b0;
        check("t4_same_pending", 32'(bus.pending), 7);
        check("t4_same_wr_baddr", 32'(bus.wr_baddr), 2);
        wait_sop("t4_sop_next", 10);
        check("t4_next_baddr", 32'(bus.tx_baddr), 2);
        flush_pulse();
        check("t4_flush_ovf", 32'(bus.overflow), 0);

        // Watchdog expiry and retry of the same bank
        wr_data();
        wait_sop("t5_sop", 10);
        check("t5_baddr", 32'(bus.tx_baddr), 1);
        check("t5_tmo0", 32'(bus.timeout), 0);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            gap++;
            if (bus.tx_sop === 1'b1) break;
        end
        check("t5_retry_gap", 32'(gap), 17);
        check("t5_tmo1", 32'(bus.timeout), 1);
        check("t5_retry_baddr", 32'(bus.tx_baddr), 1);
        tick();
        done_pulse();
        check("t5_pending", 32'(bus.pending), 0);
        check("t5_tmo_sticky", 32'(bus.timeout), 1);

        // Flush during WAIT with four banks pending
        flush_pulse();
        check("t6_tmo_clr", 32'(bus.timeout), 0);
        bus.usb_full = 1'b1;
        repeat (4) wr_data();
        bus.usb_full = 1'b0;
        wait_sop("t6_sop", 10);
        tick(2);
        check("t6_pending4", 32'(bus.pending), 4);
        check("t6_busy1", 32'(bus.busy), 1);
        flush_pulse();
        check("t6_busy0", 32'(bus.busy), 0);
        check("t6_pending0", 32'(bus.pending), 0);
        check("t6_wr_baddr", 32'(bus.wr_baddr), 1);
        check("t6_sop0", 32'(bus.tx_sop), 0);
        count_sops(10, c);
        check("t6_no_sop", 32'(c), 0);

        // Reset mid-transfer abandons it
        wr_data();
        wait_sop("t7_sop", 10);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_busy", 32'(bus.busy), 0);
        check("t7_pending", 32'(bus.pending), 0);
        count_sops(10, c);
        check("t7_no_sop", 32'(c), 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
